// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the mips debug run/step controller: mode codes,
// FSM state constants and small mode-sequencing helpers.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BURST = 2'd2
  } mode_e;

  localparam logic [2:0] ST_RUN          = 3'd0;
  localparam logic [2:0] ST_STEP_IDLE    = 3'd1;
  localparam logic [2:0] ST_STEP_PULSE   = 3'd2;
  localparam logic [2:0] ST_BURST_IDLE   = 3'd3;
  localparam logic [2:0] ST_BURST_ACTIVE = 3'd4;
  localparam logic [2:0] ST_HALT         = 3'd5;
  localparam logic [2:0] ST_RESUME       = 3'd6;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:  return MODE_STEP;
      MODE_STEP: return MODE_BURST;
      default:   return MODE_RUN;
    endcase
  endfunction

  function automatic logic [2:0] idle_state(input mode_e m);
    case (m)
      MODE_STEP:  return ST_STEP_IDLE;
      MODE_BURST: return ST_BURST_IDLE;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/mips_dbg_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle
// rising-edge strobe taken from the last stage.
module mips_dbg_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// Run/step/burst clock-enable controller for the mips core.
// Define MIPS_STEP_BP_EN to build the PC breakpoint comparators and HALT.
module mips_step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BP      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   change,
  input  logic                   step,
  input  logic [CNT_W-1:0]       burst_len,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  output logic                   cpu_en,
  output logic [1:0]             mode,
  output logic                   halted,
  output logic [CNT_W-1:0]       en_count
);

  logic             change_rise, step_rise, bp_hit;
  logic [2:0]       state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic             skip_q, skip_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] count_q, count_d;

  mips_dbg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_change_sync (
    .clock (clock),
    .reset (reset),
    .d     (change),
    .rise  (change_rise)
  );

  mips_dbg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clock (clock),
    .reset (reset),
    .d     (step),
    .rise  (step_rise)
  );

`ifdef MIPS_STEP_BP_EN
  logic [NUM_BP-1:0] bp_match;

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_valid[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

  // The resumed instruction sits on the breakpoint PC, so skip masks one hit.
  assign bp_hit = (|bp_match) & ~skip_q;
  assign halted = (state_q == ST_HALT);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
  assign halted    = 1'b0;
`endif

  assign cpu_en   = en_q & ~bp_hit;
  assign mode     = mode_q;
  assign en_count = count_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    en_d    = en_q;
    burst_d = burst_q;
    skip_d  = skip_q & ~cpu_en;
    count_d = count_q + CNT_W'(cpu_en);

    if (change_rise) begin
      // A mode change overrides everything, including a coincident step edge.
      mode_d  = next_mode(mode_q);
      state_d = idle_state(mode_d);
      en_d    = (mode_d == MODE_RUN);
      burst_d = '0;
      skip_d  = 1'b0;
    end else if (bp_hit && en_q) begin
      state_d = ST_HALT;
      en_d    = 1'b0;
      burst_d = '0;
    end else begin
      case (state_q)
        ST_STEP_IDLE: begin
          if (step_rise) begin
            state_d = ST_STEP_PULSE;
            en_d    = 1'b1;
          end
        end
        ST_STEP_PULSE: begin
          state_d = ST_STEP_IDLE;
          en_d    = 1'b0;
        end
        ST_BURST_IDLE: begin
          if (step_rise) begin
            state_d = ST_BURST_ACTIVE;
            en_d    = 1'b1;
            burst_d = (burst_len == '0) ? CNT_W'(1) : burst_len;
          end
        end
        ST_BURST_ACTIVE: begin
          if (cpu_en) begin
            burst_d = burst_q - CNT_W'(1);
            if (burst_q == CNT_W'(1)) begin
              state_d = ST_BURST_IDLE;
              en_d    = 1'b0;
            end
          end
        end
        ST_HALT: begin
          if (step_rise) begin
            state_d = ST_RESUME;
            en_d    = 1'b1;
            skip_d  = 1'b1;
          end
        end
        ST_RESUME: begin
          state_d = idle_state(mode_q);
          en_d    = (mode_q == MODE_RUN);
        end
        default: begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_RUN;
      en_q    <= 1'b0;
      skip_q  <= 1'b0;
      burst_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      skip_q  <= skip_d;
      burst_q <= burst_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Self-checking bench for mips_step_ctrl: scoreboarded enable-cycle counts
// for run/step/burst, breakpoint halt/resume, reset and counter wrap.
module tb_mips_step_ctrl;

  localparam int PC_W   = 32;
  localparam int CNT_W  = 16;
  localparam int NUM_BP = 2;

  logic                   clock = 1'b0;
  logic                   reset, change, step;
  logic [CNT_W-1:0]       burst_len;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_valid;
  logic                   cpu_en, halted;
  logic [1:0]             mode;
  logic [CNT_W-1:0]       en_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit core_run = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  mips_step_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .SYNC_STAGES(2), .NUM_BP(NUM_BP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .change    (change),
    .step      (step),
    .burst_len (burst_len),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .halted    (halted),
    .en_count  (en_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: observed 0x%0h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  // One clock; the behavioural core advances its PC on enabled cycles.
  task automatic tick();
    logic en_before;
    en_before = cpu_en;
    @(posedge clock);
    #1;
    if (core_run && en_before) pc = pc + 32'd4;
  endtask

  // Raise the selected inputs for two cycles, optionally re-raise step later,
  // and count enabled cycles inside an n-cycle window.
  task automatic edge_window(input bit do_change, input bit do_step, input int n,
                             input int step2_at, output int ens, output int first_idx,
                             output int last_idx);
    ens       = 0;
    first_idx = -1;
    last_idx  = -1;
    change    = do_change;
    step      = do_step;
    for (int i = 0; i < n; i++) begin
      if (i == 2) begin
        change = 1'b0;
        step   = 1'b0;
      end
      if (step2_at >= 0 && i == step2_at)     step = 1'b1;
      if (step2_at >= 0 && i == step2_at + 2) step = 1'b0;
      if (cpu_en) begin
        ens++;
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
      tick();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ens, fi, li;
    logic [CNT_W-1:0] base, delta;

    reset = 1'b1; change = 1'b0; step = 1'b0; burst_len = '0;
    pc = '0; bp_addr = '0; bp_valid = '0;
    repeat (3) tick();
    check("rst_cpu_en",   32'(cpu_en),   0);
    check("rst_mode",     32'(mode),     0);
    check("rst_halted",   32'(halted),   0);
    check("rst_en_count", 32'(en_count), 0);

    // Free run
    reset = 1'b0;
    tick();
    check("run_first_en", 32'(cpu_en),   1);
    check("run_count0",   32'(en_count), 0);
    sb_push("run_ens", 8);
    sb_push("run_count", 8);
    edge_window(1'b0, 1'b0, 8, -1, ens, fi, li);
    sb_pop(ens);
    sb_pop(32'(en_count));

    // Single step
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    check("step_mode",    32'(mode),   1);
    check("step_idle_en", 32'(cpu_en), 0);
    base = en_count;
    for (int k = 0; k < 2; k++) begin
      sb_push("step_ens", 1);
      sb_push("step_latency", 3);
      edge_window(1'b0, 1'b1, 8, -1, ens, fi, li);
      sb_pop(ens);
      sb_pop(fi);
    end
    delta = en_count - base;
    check("step_count_delta", 32'(delta), 2);

    // Burst
    sb_push("burst_sel_ens", 0);
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    sb_pop(ens);
    check("burst_mode", 32'(mode), 2);
    burst_len = 16'd5;
    sb_push("burst5_ens", 5);
    sb_push("burst5_latency", 3);
    sb_push("burst5_span", 5);
    edge_window(1'b0, 1'b1, 14, -1, ens, fi, li);
    sb_pop(ens);
    sb_pop(fi);
    sb_pop(li - fi + 1);
    burst_len = 16'd0;
    sb_push("burst0_ens", 1);
    edge_window(1'b0, 1'b1, 8, -1, ens, fi, li);
    sb_pop(ens);

    // Simultaneous change+step from STEP_IDLE; step during an active burst
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    check("to_run_mode", 32'(mode), 0);
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    check("to_step_mode", 32'(mode), 1);
    sb_push("simul_ens", 0);
    edge_window(1'b1, 1'b1, 8, -1, ens, fi, li);
    sb_pop(ens);
    check("simul_mode", 32'(mode), 2);
    burst_len = 16'd10;
    sb_push("burst10_ens", 10);
    edge_window(1'b0, 1'b1, 20, 6, ens, fi, li);
    sb_pop(ens);
    check("burst10_idle_en", 32'(cpu_en), 0);

    // Breakpoint in RUN mode
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    check("bp_run_mode", 32'(mode), 0);
    bp_addr  = {32'h0000_0000, 32'h0000_0010};
    bp_valid = 2'b01;
    pc       = '0;
    core_run = 1'b1;
    for (int i = 0; i < 20 && pc != 32'h10; i++) tick();
    check("bp_pc_reached", pc, 32'h10);
`ifdef MIPS_STEP_BP_EN
    check("bp_same_cycle_en", 32'(cpu_en), 0);
    tick();
    check("bp_halted",      32'(halted), 1);
    check("bp_halt_en",     32'(cpu_en), 0);
    check("bp_halt_pc",     pc,          32'h10);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    check("resume_wait_en", 32'(cpu_en), 0);
    tick();
    check("resume_en",      32'(cpu_en), 1);
    check("resume_pc",      pc,          32'h10);
    check("resume_halted",  32'(halted), 0);
    tick();
    check("resume_next_pc", pc,          32'h14);
    check("resume_run_en",  32'(cpu_en), 1);
    check("resume_mode",    32'(mode),   0);
`else
    check("nobp_en", 32'(cpu_en), 1);
    tick();
    check("nobp_halted",  32'(halted), 0);
    check("nobp_next_pc", pc,          32'h14);
`endif
    core_run = 1'b0;
    bp_valid = '0;

    // Reset in the middle of a burst
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    edge_window(1'b1, 1'b0, 8, -1, ens, fi, li);
    check("mid_mode", 32'(mode), 2);
    burst_len = 16'd20;
    step = 1'b1;
    repeat (2) tick();
    step = 1'b0;
    repeat (4) tick();
    check("midburst_en", 32'(cpu_en), 1);
    reset = 1'b1;
    tick();
    check("midrst_mode",   32'(mode),     0);
    check("midrst_count",  32'(en_count), 0);
    check("midrst_halted", 32'(halted),   0);
    check("midrst_en",     32'(cpu_en),   0);
    reset = 1'b0;

    // en_count wrap
    tick();
    check("wrap_start", 32'(en_count), 0);
    repeat (65535) tick();
    check("wrap_ffff", 32'(en_count), 32'h0000_FFFF);
    tick();
    check("wrap_zero", 32'(en_count), 0);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
